// File: rtl/wino_tile_feeder.sv
// Streaming front end for the Winograd F(2x2,3x3) datapath: buffers four image
// rows of a row-major pixel stream and emits overlapping 4x4 tiles at stride 2.
module wino_tile_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [127:0] tile_out,
  output logic         tile_valid,
  input  logic         tile_ready,
  output logic [7:0]   tile_row,
  output logic [7:0]   tile_col,
  output logic         tile_last
);

  localparam int DATA_W = 8;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] FILL_COL_LAST = CW'(IMG_W - 1);
  localparam logic [7:0] COL_LAST = 8'((IMG_W - 4) / 2);
  localparam logic [7:0] ROW_LAST = 8'((IMG_H - 4) / 2);

  typedef enum logic [1:0] {
    FILL4 = 2'd0,
    EMIT  = 2'd1,
    FILL2 = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        fill_row;
  logic [CW-1:0]     fill_col;
  logic [DATA_W-1:0] rb [4][IMG_W];
  logic [CW-1:0]     cidx;

  logic pix_acc;
  logic tile_hs;
  logic band_end;
  logic frame_end;
  logic shift_rows;

  always_comb begin
    pix_acc    = pix_valid && pix_ready;
    tile_hs    = (state == EMIT) && tile_valid && tile_ready;
    band_end   = (tile_col == COL_LAST);
    frame_end  = band_end && (tile_row == ROW_LAST);
    shift_rows = tile_hs && band_end && !frame_end;
  end

  // Row buffer: pixel data only, never reset. Row shift and pixel writes are
  // mutually exclusive because pix_ready is low throughout EMIT.
  always_ff @(posedge clk) begin
    if (shift_rows) begin
      for (int c = 0; c < IMG_W; c++) begin
        rb[0][c] <= rb[2][c];
        rb[1][c] <= rb[3][c];
      end
    end
    if (pix_acc) begin
      rb[fill_row][fill_col] <= pix_in;
    end
  end

  // Tile window: element (i,j) is buffer row i, column 2*tile_col+j.
  always_comb begin
    tile_out = '0;
    cidx     = '0;
    if (tile_valid) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          cidx = CW'({tile_col, 1'b0} + 9'(j));
          tile_out[32*i+8*j +: 8] = rb[i][cidx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FILL4;
      pix_ready  <= 1'b0;
      tile_valid <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
      tile_last  <= 1'b0;
      fill_row   <= '0;
      fill_col   <= '0;
    end else begin
      case (state)
        FILL4, FILL2: begin
          if (!pix_ready) begin
            pix_ready <= 1'b1;
          end
          if (pix_acc) begin
            if (fill_col == FILL_COL_LAST) begin
              fill_col <= '0;
              if (fill_row == 2'd3) begin
                fill_row   <= '0;
                pix_ready  <= 1'b0;
                tile_valid <= 1'b1;
                tile_last  <= (tile_row == ROW_LAST) && (COL_LAST == 8'd0);
                state      <= EMIT;
              end else begin
                fill_row <= fill_row + 2'd1;
              end
            end else begin
              fill_col <= fill_col + 1'b1;
            end
          end
        end
        EMIT: begin
          if (tile_hs) begin
            if (!band_end) begin
              tile_col  <= tile_col + 8'd1;
              tile_last <= (tile_row == ROW_LAST) && ((tile_col + 8'd1) == COL_LAST);
            end else begin
              tile_valid <= 1'b0;
              pix_ready  <= 1'b1;
              tile_col   <= '0;
              tile_last  <= 1'b0;
              if (frame_end) begin
                tile_row <= '0;
                fill_row <= 2'd0;
                state    <= FILL4;
              end else begin
                // Rows 2..3 slide down to 0..1; refill only the lower pair.
                tile_row <= tile_row + 8'd1;
                fill_row <= 2'd2;
                state    <= FILL2;
              end
            end
          end
        end
        default: state <= FILL4;
      endcase
    end
  end

endmodule

// File: tb/tb_wino_tile_feeder.sv
// Self-checking bench for wino_tile_feeder: image-level reference model plus
// fixed tile vectors and hand-written stall/reset/minimum-size sequences.
module tb_wino_tile_feeder;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TC = (W - 2) / 2;
  localparam int TR = (H - 2) / 2;
  localparam int NT = TC * TR;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [127:0] tile_out;
  logic         tile_valid;
  logic         tile_ready = 1'b1;
  logic [7:0]   tile_row;
  logic [7:0]   tile_col;
  logic         tile_last;

  logic [7:0]   p4_in = '0;
  logic         p4_valid = 1'b0;
  logic         p4_ready;
  logic [127:0] t4_out;
  logic         t4_valid;
  logic         t4_ready = 1'b0;
  logic [7:0]   t4_row;
  logic [7:0]   t4_col;
  logic         t4_last;

  wino_tile_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .tile_out(tile_out), .tile_valid(tile_valid),
    .tile_ready(tile_ready), .tile_row(tile_row), .tile_col(tile_col),
    .tile_last(tile_last)
  );

  wino_tile_feeder #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rstn(rstn), .pix_in(p4_in), .pix_valid(p4_valid),
    .pix_ready(p4_ready), .tile_out(t4_out), .tile_valid(t4_valid),
    .tile_ready(t4_ready), .tile_row(t4_row), .tile_col(t4_col),
    .tile_last(t4_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference model: the image as accepted so far, plus the expected tile order
  logic [7:0]   img [H][W];
  logic [127:0] cap [NT];
  logic         cap_last [NT];
  int px_cnt = 0, exp_t = 0, tiles_done = 0, mtr, mtc;
  bit fill_pend = 0, hs_prev = 0, hs_band_last = 0, stall_prev = 0;
  logic [127:0] prev_out;
  logic [16:0]  prev_idx;

  function automatic logic [127:0] exp_tile(input int tr, input int tc);
    logic [127:0] t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[32*i+8*j +: 8] = img[2*tr+i][2*tc+j];
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      px_cnt = 0; exp_t = 0; fill_pend = 0; hs_prev = 0; stall_prev = 0;
    end else begin
      mtr = exp_t / TC;
      mtc = exp_t % TC;
      if (fill_pend) begin
        check("fill_to_tile_valid", tile_valid, 1'b1);
        check("fill_to_pix_ready", pix_ready, 1'b0);
      end
      if (hs_prev) begin
        check("post_hs_tile_valid", tile_valid, !hs_band_last);
        check("post_hs_pix_ready", pix_ready, hs_band_last);
      end
      if (stall_prev) begin
        check("stall_tile_valid", tile_valid, 1'b1);
        check("stall_tile_out", tile_out, prev_out);
        check("stall_idx", {tile_row, tile_col, tile_last}, prev_idx);
      end
      fill_pend = 0;
      hs_prev = 0;
      stall_prev = tile_valid && !tile_ready;
      prev_out = tile_out;
      prev_idx = {tile_row, tile_col, tile_last};
      if (pix_valid && pix_ready) begin
        if (px_cnt < W * H) img[px_cnt / W][px_cnt % W] = pix_in;
        px_cnt++;
        if (px_cnt == (2 * mtr + 4) * W) fill_pend = 1;
      end
      if (tile_valid) begin
        check("no_overlap", pix_ready, 1'b0);
        if (tile_ready) begin
          check("tile_data", tile_out, exp_tile(mtr, mtc));
          check("tile_row", tile_row, mtr);
          check("tile_col", tile_col, mtc);
          check("tile_last", tile_last, exp_t == NT - 1);
          check("pixels_before_tile", px_cnt, (2 * mtr + 4) * W);
          cap[exp_t] = tile_out;
          cap_last[exp_t] = tile_last;
          hs_prev = 1;
          hs_band_last = (mtc == TC - 1);
          exp_t++;
          tiles_done++;
          if (exp_t == NT) begin
            exp_t = 0;
            px_cnt = 0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] pixval(input int kind, input int r, input int c);
    case (kind)
      0: return 8'(16 * r + c);
      1: return 8'hAA;
      2: return 8'(255 - (16 * r + c));
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic push(input logic [7:0] v, input bit sparse);
    int g = 0;
    if (sparse) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_in = v;
    pix_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk); #1;
        break;
      end
      g++;
      if (g > 2000) begin
        timeout("pix_accept");
        break;
      end
    end
  endtask

  task automatic wait_tiles(input int target);
    int g = 0;
    while (tiles_done < target && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (tiles_done < target) timeout("tile_count");
    @(posedge clk); #1;
  endtask

  task automatic feed_frame(input int kind, input bit sparse);
    int start = tiles_done;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        push(pixval(kind, r, c), sparse);
    pix_valid = 1'b0;
    wait_tiles(start + NT);
  endtask

  typedef struct {
    int           tr;
    int           tc;
    logic [127:0] tile;
    logic         last;
  } vec_t;
  vec_t vt [5];

  task automatic check_table();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("vec_tile_%0d_%0d", vt[k].tr, vt[k].tc), cap[vt[k].tr * TC + vt[k].tc], vt[k].tile);
      check($sformatf("vec_last_%0d_%0d", vt[k].tr, vt[k].tc), cap_last[vt[k].tr * TC + vt[k].tc], vt[k].last);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit done;
    int g;
    logic [127:0] e4;
    logic [7:0] v;

    vt[0] = '{0, 0, 128'h33323130_23222120_13121110_03020100, 1'b0};
    vt[1] = '{0, 1, 128'h35343332_25242322_15141312_05040302, 1'b0};
    vt[2] = '{1, 0, 128'h53525150_43424140_33323130_23222120, 1'b0};
    vt[3] = '{1, 1, 128'h55545352_45444342_35343332_25242322, 1'b0};
    vt[4] = '{2, 2, 128'h77767574_67666564_57565554_47464544, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_tile_valid", tile_valid, 1'b0);
    check("rst_tile_out", tile_out, '0);
    check("rst_idx", {tile_row, tile_col, tile_last}, '0);
    #1 rstn = 1'b1;
    check("rel_pix_ready_low", pix_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_pix_ready_high", pix_ready, 1'b1);

    // Base frame, dense, no backpressure
    feed_frame(0, 1'b0);
    check_table();

    // Backpressure on tile (1,1); pix_valid held high in EMIT by push()
    done = 0;
    fork
      begin
        feed_frame(0, 1'b0);
        done = 1;
      end
      begin
        g = 0;
        while (!(tile_valid && tile_row == 8'd1 && tile_col == 8'd1) && g < 2000) begin
          @(posedge clk); #1;
          g++;
        end
        if (g >= 2000) timeout("bp_tile_1_1");
        tile_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("bp_valid", tile_valid, 1'b1);
          check("bp_idx", {tile_row, tile_col, tile_last}, {8'd1, 8'd1, 1'b0});
          check("bp_out", tile_out, vt[3].tile);
        end
        tile_ready = 1'b1;
      end
    join
    check_table();

    // Sparse input: pix_valid toggles every other cycle
    feed_frame(0, 1'b1);
    check_table();

    // Back-to-back frames
    feed_frame(0, 1'b0);
    feed_frame(2, 1'b0);
    check("b2b_first_tile", cap[0], 128'hCCCDCECF_DCDDDEDF_ECEDEEEF_FCFDFEFF);

    // Random pixels with random backpressure
    done = 0;
    fork
      begin
        feed_frame(3, 1'b0);
        feed_frame(3, 1'b1);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          tile_ready = 1'($urandom_range(0, 1));
        end
        tile_ready = 1'b1;
      end
    join
    tile_ready = 1'b1;

    // Reset during tile (1,1)
    for (int k = 0; k < 6 * W; k++) push(pixval(0, k / W, k % W), 1'b0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_emit_idx", {tile_valid, tile_row, tile_col}, {1'b1, 8'd1, 8'd1});
    rstn = 1'b0;
    #1;
    check("mid_rst_pix_ready", pix_ready, 1'b0);
    check("mid_rst_tile_valid", tile_valid, 1'b0);
    check("mid_rst_tile_out", tile_out, '0);
    check("mid_rst_idx", {tile_row, tile_col, tile_last}, '0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    feed_frame(1, 1'b0);
    check("aa_first_tile", cap[0], {16{8'hAA}});

    // Minimum 4x4 size: one tile per frame, FILL4/EMIT alternate
    for (int f = 0; f < 2; f++) begin
      e4 = '0;
      for (int k = 0; k < 16; k++) begin
        v = 8'($urandom);
        e4[32*(k/4)+8*(k%4) +: 8] = v;
        p4_in = v;
        p4_valid = 1'b1;
        g = 0;
        while (1) begin
          @(negedge clk);
          if (p4_ready) begin
            @(posedge clk); #1;
            break;
          end
          g++;
          if (g > 200) begin
            timeout("p4_accept");
            break;
          end
        end
      end
      p4_valid = 1'b0;
      check("min_tile_valid", t4_valid, 1'b1);
      check("min_pix_ready", p4_ready, 1'b0);
      check("min_tile_out", t4_out, e4);
      check("min_idx", {t4_row, t4_col, t4_last}, {8'd0, 8'd0, 1'b1});
      t4_ready = 1'b1;
      @(posedge clk); #1;
      t4_ready = 1'b0;
      check("min_post_valid", t4_valid, 1'b0);
      check("min_post_ready", p4_ready, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
